// File: rtl/qproc_time_cmd_q_if.sv
// rtl/qproc_time_cmd_q_if.sv - command-in / issue-out bundle of the core-side time-command queue
interface qproc_time_cmd_q_if #(
    parameter int DW = 32
);
    logic          cmd_vld_i;
    logic [3:0]    cmd_op_i;
    logic [DW-1:0] cmd_dt_i;
    logic          cmd_rdy_o;
    logic          int_time_en_o;
    logic [3:0]    int_time_cmd_o;
    logic [DW-1:0] int_time_dt_o;

    modport master (
        output cmd_vld_i, cmd_op_i, cmd_dt_i,
        input  cmd_rdy_o, int_time_en_o, int_time_cmd_o, int_time_dt_o
    );

    modport slave (
        input  cmd_vld_i, cmd_op_i, cmd_dt_i,
        output cmd_rdy_o, int_time_en_o, int_time_cmd_o, int_time_dt_o
    );
endinterface

// File: rtl/qproc_time_cmd_q.sv
// rtl/qproc_time_cmd_q.sv - time-command FIFO issuing one-cycle strobes, spacing t_clk-bound commands
// Optional issued/drop counters are built when TIME_CMD_STATS_EN is defined.
module qproc_time_cmd_q #(
    parameter int DEPTH   = 8,
    parameter int GAP_CYC = 4,
    parameter int DW      = 32
) (
    input  logic                   c_clk_i,
    input  logic                   c_rst_ni,
    input  logic                   flush_i,
    qproc_time_cmd_q_if.slave      cmd_if,
    output logic [$clog2(DEPTH):0] fifo_cnt_o,
    output logic                   ovf_o,
    output logic                   busy_o,
    output logic [15:0]            issued_cnt_o,
    output logic [15:0]            drop_cnt_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;
    state_t state_q, state_d;

    logic [3:0]    mem_op [DEPTH];
    logic [DW-1:0] mem_dt [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    gap_cnt;
    logic [3:0]    pend_op;
    logic [DW-1:0] pend_dt;

    logic full, empty, head_cdc, head_ok, push, drop, pop, strobe;

    assign full     = fifo_cnt_o == (AW+1)'(DEPTH);
    assign empty    = fifo_cnt_o == '0;
    assign head_cdc = |mem_op[rd_ptr][1:0];
    // A t_clk-bound head waits for the gap counter; everything behind it waits too.
    assign head_ok  = !empty && (!head_cdc || gap_cnt == '0);
    assign push     = cmd_if.cmd_vld_i && !full && (cmd_if.cmd_op_i != '0) && !flush_i;
    assign drop     = cmd_if.cmd_vld_i && full && (cmd_if.cmd_op_i != '0) && !flush_i;
    assign strobe   = (state_q == S_ISSUE) && !flush_i;

    assign cmd_if.cmd_rdy_o = !full;
    assign busy_o           = !empty || (gap_cnt != '0);

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_ok) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (head_ok) pop = 1'b1;
                else         state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            pop     = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge c_clk_i) begin
        if (push) begin
            mem_op[wr_ptr] <= cmd_if.cmd_op_i;
            mem_dt[wr_ptr] <= cmd_if.cmd_dt_i;
        end
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
            ovf_o      <= 1'b0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt_o <= '0;
            ovf_o      <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_o <= fifo_cnt_o + 1'b1;
                2'b01:   fifo_cnt_o <= fifo_cnt_o - 1'b1;
                default: fifo_cnt_o <= fifo_cnt_o;
            endcase
            if (drop) ovf_o <= 1'b1;
        end
    end

    // The gap counter survives flush: a t_clk pulse may still be crossing.
    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            pend_op               <= '0;
            pend_dt               <= '0;
            gap_cnt               <= '0;
            cmd_if.int_time_en_o  <= 1'b0;
            cmd_if.int_time_cmd_o <= '0;
            cmd_if.int_time_dt_o  <= '0;
        end else begin
            if (pop) begin
                pend_op <= mem_op[rd_ptr];
                pend_dt <= mem_dt[rd_ptr];
            end
            if (pop && head_cdc)    gap_cnt <= 4'(GAP_CYC);
            else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
            if (strobe) begin
                cmd_if.int_time_en_o  <= 1'b1;
                cmd_if.int_time_cmd_o <= pend_op;
                cmd_if.int_time_dt_o  <= pend_dt;
            end else begin
                cmd_if.int_time_en_o  <= 1'b0;
                cmd_if.int_time_cmd_o <= '0;
            end
        end
    end

`ifdef TIME_CMD_STATS_EN
    logic [15:0] issued_q, drop_q;

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            issued_q <= '0;
            drop_q   <= '0;
        end else if (flush_i) begin
            issued_q <= '0;
            drop_q   <= '0;
        end else begin
            if (strobe && issued_q != 16'hFFFF) issued_q <= issued_q + 1'b1;
            if (drop && drop_q != 16'hFFFF)     drop_q   <= drop_q + 1'b1;
        end
    end

    assign issued_cnt_o = issued_q;
    assign drop_cnt_o   = drop_q;
`else
    assign issued_cnt_o = '0;
    assign drop_cnt_o   = '0;
`endif
endmodule

// File: tb/tb_qproc_time_cmd_q.sv
// tb/tb_qproc_time_cmd_q.sv - directed and randomized checks of qproc_time_cmd_q against a timestamp queue model
module tb_qproc_time_cmd_q;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int DW    = 32;

    logic c_clk_i  = 1'b0;
    logic c_rst_ni = 1'b0;
    logic flush_i  = 1'b0;
    logic [3:0]  fifo_cnt;
    logic        ovf, busy;
    logic [15:0] issued_cnt, drop_cnt;

    always #5 c_clk_i = ~c_clk_i;

    qproc_time_cmd_q_if #(.DW(DW)) bus ();

    qproc_time_cmd_q #(.DEPTH(DEPTH), .GAP_CYC(GAP), .DW(DW)) dut (
        .c_clk_i      (c_clk_i),
        .c_rst_ni     (c_rst_ni),
        .flush_i      (flush_i),
        .cmd_if       (bus),
        .fifo_cnt_o   (fifo_cnt),
        .ovf_o        (ovf),
        .busy_o       (busy),
        .issued_cnt_o (issued_cnt),
        .drop_cnt_o   (drop_cnt)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] dt;
    } ent_t;

    // Model: an entry may leave the queue on any edge once it is the head, and a
    // t_clk-bound entry only GAP+1 or more edges after the previous one left.
    ent_t        mq[$];
    ent_t        pend;
    bit          pend_v;
    int          e, last_cdc, base;
    bit          x_en, x_ovf;
    logic [3:0]  x_cmd;
    logic [31:0] x_dt;
    int          x_iss, x_drop;
    int          obs_e[$];
    logic [31:0] obs_d[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend_v   = 0;
        x_en     = 0;
        x_cmd    = '0;
        x_dt     = '0;
        x_ovf    = 0;
        x_iss    = 0;
        x_drop   = 0;
        last_cdc = e - 1000;
    endtask

    function automatic int gap_now();
        int d = e - last_cdc;
        return (d < GAP) ? GAP - d : 0;
    endfunction

    task automatic model_step(input bit v, input logic [3:0] o, input logic [31:0] d, input bit f);
        int qb;
        e++;
        qb = mq.size();
        if (f) begin
            mq.delete();
            pend_v = 0;
            x_en   = 0;
            x_cmd  = '0;
            x_ovf  = 0;
            x_iss  = 0;
            x_drop = 0;
        end else begin
            x_en  = pend_v;
            x_cmd = pend_v ? pend.op : 4'h0;
            if (pend_v) begin
                x_dt = pend.dt;
                if (x_iss < 65535) x_iss++;
            end
            pend_v = 0;
            if (qb > 0 && (mq[0].op[1:0] == 2'b00 || e >= last_cdc + GAP + 1)) begin
                pend   = mq.pop_front();
                pend_v = 1;
                if (pend.op[1:0] != 2'b00) last_cdc = e;
            end
            if (v && o != 4'h0) begin
                if (qb < DEPTH) mq.push_back('{o, d});
                else begin
                    x_ovf = 1;
                    if (x_drop < 65535) x_drop++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("en",   bus.int_time_en_o,  x_en);
        check_eq("cmd",  bus.int_time_cmd_o, x_cmd);
        check_eq("dt",   bus.int_time_dt_o,  x_dt);
        check_eq("cnt",  fifo_cnt,           mq.size());
        check_eq("rdy",  bus.cmd_rdy_o,      mq.size() < DEPTH);
        check_eq("ovf",  ovf,                x_ovf);
        check_eq("busy", busy,               (mq.size() != 0) || (gap_now() != 0));
`ifdef TIME_CMD_STATS_EN
        check_eq("issued", issued_cnt, x_iss);
        check_eq("drop",   drop_cnt,   x_drop);
`else
        check_eq("issued", issued_cnt, 0);
        check_eq("drop",   drop_cnt,   0);
`endif
        if (bus.int_time_en_o) begin
            obs_e.push_back(e - base);
            obs_d.push_back(bus.int_time_dt_o);
        end
    endtask

    task automatic cycle(input bit v, input logic [3:0] o, input logic [31:0] d, input bit f);
        bus.cmd_vld_i = v;
        bus.cmd_op_i  = o;
        bus.cmd_dt_i  = d;
        flush_i       = f;
        @(posedge c_clk_i);
        model_step(v, o, d, f);
        @(negedge c_clk_i);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 4'h0, 32'h0, 0);
    endtask

    task automatic start();
        obs_e.delete();
        obs_d.delete();
        base = e + 1;
    endtask

    function automatic int obs_at(input int i);
        return (i < obs_e.size()) ? obs_e[i] : -1;
    endfunction

    function automatic logic [31:0] obs_dt(input int i);
        return (i < obs_d.size()) ? obs_d[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        bus.cmd_vld_i = 1'b0;
        bus.cmd_op_i  = '0;
        bus.cmd_dt_i  = '0;
        e = 0;
        model_reset();
        repeat (3) @(negedge c_clk_i);
        compare_all();
        c_rst_ni = 1'b1;

        // single ref_set: strobe at edge 2 only
        idle(2);
        start();
        cycle(1, 4'b0100, 32'h1234, 0);
        check_eq("s1_cnt_after_push", fifo_cnt, 1);
        idle(1);
        check_eq("s1_cnt_after_pop", fifo_cnt, 0);
        idle(4);
        check_eq("s1_nstrobe", obs_e.size(), 1);
        check_eq("s1_edge", obs_at(0), 2);
        check_eq("s1_dt", obs_dt(0), 32'h1234);

        // time_updt, time_rst, ref_inc: strobes at 2, 7, 8
        idle(8);
        start();
        cycle(1, 4'b0010, 32'd10, 0);
        cycle(1, 4'b0001, 32'd11, 0);
        cycle(1, 4'b1000, 32'd12, 0);
        idle(10);
        check_eq("s2_nstrobe", obs_e.size(), 3);
        check_eq("s2_edge0", obs_at(0), 2);
        check_eq("s2_edge1", obs_at(1), 7);
        check_eq("s2_edge2", obs_at(2), 8);

        // three ref_inc back-to-back
        idle(8);
        start();
        for (int i = 1; i <= 3; i++) cycle(1, 4'b1000, 32'(i), 0);
        idle(4);
        check_eq("s3_nstrobe", obs_e.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("s3_edge", obs_at(i), 2 + i);
            check_eq("s3_data", obs_dt(i), 32'(i + 1));
        end

        // fill with t_clk-bound commands until full, including a push blocked in a pop cycle
        idle(8);
        start();
        for (int i = 0; i < 12; i++) begin
            cycle(1, (i % 2 != 0) ? 4'b0010 : 4'b0001, 32'(100 + i), 0);
            if (i == 10) begin
                check_eq("s4_full_cnt", fifo_cnt, 8);
                check_eq("s4_full_rdy", bus.cmd_rdy_o, 0);
                check_eq("s4_full_ovf", ovf, 1);
            end
        end
        check_eq("s4_popfull_cnt", fifo_cnt, 7);
`ifdef TIME_CMD_STATS_EN
        check_eq("s4_drop_cnt", drop_cnt, 2);
`endif
        // flush two cycles after the strobe at edge 12; gap keeps running
        idle(2);
        cycle(0, 4'h0, 32'h0, 1);
        check_eq("s5_cnt", fifo_cnt, 0);
        check_eq("s5_ovf", ovf, 0);
        check_eq("s5_en", bus.int_time_en_o, 0);
        cycle(1, 4'b0001, 32'hAB, 0);
        idle(6);
        check_eq("s5_nstrobe", obs_e.size(), 4);
        check_eq("s5_edge_a", obs_at(2), 12);
        check_eq("s5_edge_b", obs_at(3), 17);
        check_eq("s5_dt_b", obs_dt(3), 32'hAB);

        // async reset while a strobe is on the outputs
        idle(8);
        cycle(1, 4'b0100, 32'h55, 0);
        idle(1);
        @(posedge c_clk_i);
        #2;
        check_eq("ar_pre_en", bus.int_time_en_o, 1);
        c_rst_ni = 1'b0;
        #1;
        check_eq("ar_en",   bus.int_time_en_o,  0);
        check_eq("ar_cmd",  bus.int_time_cmd_o, 0);
        check_eq("ar_dt",   bus.int_time_dt_o,  0);
        check_eq("ar_cnt",  fifo_cnt,           0);
        check_eq("ar_busy", busy,               0);
        @(negedge c_clk_i);
        c_rst_ni = 1'b1;
        model_reset();
        check_eq("ar_rdy", bus.cmd_rdy_o, 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit          v, f;
            int          r;
            logic [3:0]  o;
            v = ($urandom_range(0, 99) < 60);
            r = $urandom_range(0, 9);
            case (r)
                0:       o = 4'h0;
                1:       o = 4'b0001;
                2:       o = 4'b0010;
                3:       o = 4'b0011;
                default: o = 4'($urandom_range(1, 15));
            endcase
            f = ($urandom_range(0, 59) == 0);
            cycle(v, o, $urandom, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
